// File: rtl/vga_timing_pkg.sv
// Shared constants, mode record and helpers for the VGA raster timing generator.
package vga_timing_pkg;

    // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // The eight timing fields that describe one video mode
    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_mode_t;

    localparam vga_mode_t VGA_640X480_60 = '{
        h_active: DEF_H_ACTIVE, h_fp: DEF_H_FP, h_sync: DEF_H_SYNC, h_bp: DEF_H_BP,
        v_active: DEF_V_ACTIVE, v_fp: DEF_V_FP, v_sync: DEF_V_SYNC, v_bp: DEF_V_BP
    };

    // Length of one axis: active area plus both porches plus the sync pulse
    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle: the generator drives timing, the consumer drives the run enable.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int X_W = $clog2(vga_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP)),
    parameter int Y_W = $clog2(vga_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP))
);
    logic           en;
    logic           h_sync;
    logic           v_sync;
    logic           blank_n;
    logic [X_W-1:0] posx;
    logic [Y_W-1:0] posy;
    logic           pix_en;
    logic           line_start;
    logic           frame_start;

    modport master (
        input  en,
        output h_sync, v_sync, blank_n, posx, posy, pix_en, line_start, frame_start
    );

    modport slave (
        output en,
        input  h_sync, v_sync, blank_n, posx, posy, pix_en, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus decode of the value it moves to.
// The outputs describe the state after the coming edge so the parent can register
// them and stay aligned with the counter.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter bit POL    = 1'b0,
    localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP),
    localparam int W     = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         visible,
    output logic         sync
);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);
    localparam logic [W-1:0] VIS_END    = W'(ACTIVE);

    logic [W-1:0] count_q;

    // Next position and its region decode; count is the value held after this edge
    always_comb begin
        wrap    = step && (count_q == LAST);
        count   = count_q;
        if (step) begin
            count = wrap ? '0 : count_q + 1'b1;
        end
        visible = (count < VIS_END);
        sync    = ((count >= SYNC_FIRST) && (count < SYNC_END)) ? POL : !POL;
    end

    // Position register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count;
        end
    end
endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-clock divider, horizontal and
// vertical axis counters, registered sync/blank/position outputs and wrap strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 2
) (
    input  logic               clk,
    input  logic               rst,
    vga_timing_gen_if.master   bus
);
    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int X_W     = $clog2(H_TOTAL);
    localparam int Y_W     = $clog2(V_TOTAL);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // A zero-length region or a zero divide ratio has no meaningful raster
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CLK_DIV < 1) begin : g_bad_params
        $error("vga_timing_gen: timing fields must be nonzero and CLK_DIV at least 1");
    end

    logic [DIV_W-1:0] div_cnt;
    logic             div_last;
    logic             pix_en;

    logic [X_W-1:0]   h_next;
    logic             h_wrap, h_vis_next, h_sync_next;
    logic [Y_W-1:0]   v_next;
    logic             v_wrap, v_vis_next, v_sync_next;
    logic             vis_next;

    logic             h_sync_q, v_sync_q, blank_n_q, line_start_q, frame_start_q;
    logic [X_W-1:0]   posx_q;
    logic [Y_W-1:0]   posy_q;

    assign div_last = (div_cnt == DIV_LAST);
    assign pix_en   = rst && bus.en && div_last;
    assign vis_next = h_vis_next && v_vis_next;

    // Pixel divider: counts system clocks per pixel, frozen while the raster is paused
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (bus.en) begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h_axis (
        .clk     (clk),
        .rst     (rst),
        .step    (pix_en),
        .count   (h_next),
        .wrap    (h_wrap),
        .visible (h_vis_next),
        .sync    (h_sync_next)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v_axis (
        .clk     (clk),
        .rst     (rst),
        .step    (h_wrap),
        .count   (v_next),
        .wrap    (v_wrap),
        .visible (v_vis_next),
        .sync    (v_sync_next)
    );

    // Output registers load the decode of the next counter values so they line up with the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_sync_q      <= !H_POL;
            v_sync_q      <= !V_POL;
            blank_n_q     <= 1'b1;
            posx_q        <= '0;
            posy_q        <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_sync_q      <= h_sync_next;
            v_sync_q      <= v_sync_next;
            blank_n_q     <= vis_next;
            posx_q        <= vis_next ? h_next : '0;
            posy_q        <= vis_next ? v_next : '0;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
        end
    end

    assign bus.h_sync      = h_sync_q;
    assign bus.v_sync      = v_sync_q;
    assign bus.blank_n     = blank_n_q;
    assign bus.posx        = posx_q;
    assign bus.posy        = posy_q;
    assign bus.pix_en      = pix_en;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
endmodule
